// File: rtl/ub_port_scheduler.sv
// Unified buffer burst scheduler: independent read/write ports, compute-first priority with host starvation bound.
// Optional read-after-write collision stall is enabled by defining UB_SCHED_HAZARD_EN.

module ub_port_sched_core #(
  parameter int ADDR_W       = 12,
  parameter int LEN_W        = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_c,
  input  logic              req_h,
  input  logic [ADDR_W-1:0] base_c,
  input  logic [ADDR_W-1:0] base_h,
  input  logic [LEN_W-1:0]  len_c,
  input  logic [LEN_W-1:0]  len_h,
  input  logic              stall,
  output logic              busy,
  output logic              owner,
  output logic [ADDR_W-1:0] addr,
  output logic              gnt_c,
  output logic              gnt_h,
  output logic              beat_c,
  output logic              beat_h,
  output logic              done_c,
  output logic              done_h
);
  typedef enum logic {IDLE, BURST} state_t;
  localparam logic [7:0] LIM = 8'(STARVE_LIMIT);

  state_t            state, state_nxt;
  logic              owner_nxt, first, first_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [LEN_W-1:0]  rem, rem_nxt;
  logic [7:0]        cnt, cnt_nxt;
  logic              beat, last, arb, win_c, win_h, host_pend;

  assign busy      = (state == BURST);
  assign beat      = busy && !stall;
  assign last      = beat && (rem == '0);
  // Arbitration in IDLE and on the last beat gives zero-bubble chaining.
  assign arb       = (state == IDLE) || last;
  assign win_h     = arb && req_h && ((cnt >= LIM) || !req_c);
  assign win_c     = arb && req_c && !win_h;
  // Host already won but its first beat has not issued yet: not waiting.
  assign host_pend = busy && owner && first;

  assign gnt_c  = beat && first && !owner;
  assign gnt_h  = beat && first && owner;
  assign beat_c = beat && !owner;
  assign beat_h = beat && owner;
  assign done_c = last && !owner;
  assign done_h = last && owner;

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    first_nxt = first;
    addr_nxt  = addr;
    rem_nxt   = rem;
    cnt_nxt   = cnt;
    if (win_c || win_h) begin
      state_nxt = BURST;
      owner_nxt = win_h;
      first_nxt = 1'b1;
      addr_nxt  = win_h ? base_h : base_c;
      rem_nxt   = win_h ? len_h : len_c;
    end else if (arb) begin
      state_nxt = IDLE;
    end else if (beat) begin
      addr_nxt  = addr + ADDR_W'(1);
      rem_nxt   = rem - LEN_W'(1);
      first_nxt = 1'b0;
    end
    if (win_h)
      cnt_nxt = 8'd0;
    else if (req_h && !host_pend && (cnt != 8'hFF))
      cnt_nxt = cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 1'b0;
      first <= 1'b0;
      addr  <= '0;
      rem   <= '0;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      first <= first_nxt;
      addr  <= addr_nxt;
      rem   <= rem_nxt;
      cnt   <= cnt_nxt;
    end
  end
endmodule

module ub_port_scheduler #(
  parameter int ADDR_W       = 12,
  parameter int LEN_W        = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              act_req_i,
  input  logic              hrd_req_i,
  input  logic              acc_req_i,
  input  logic              hwr_req_i,
  input  logic [ADDR_W-1:0] act_base_i,
  input  logic [ADDR_W-1:0] hrd_base_i,
  input  logic [ADDR_W-1:0] acc_base_i,
  input  logic [ADDR_W-1:0] hwr_base_i,
  input  logic [LEN_W-1:0]  act_len_i,
  input  logic [LEN_W-1:0]  hrd_len_i,
  input  logic [LEN_W-1:0]  acc_len_i,
  input  logic [LEN_W-1:0]  hwr_len_i,
  output logic              act_gnt_o,
  output logic              hrd_gnt_o,
  output logic              acc_gnt_o,
  output logic              hwr_gnt_o,
  output logic              act_beat_o,
  output logic              hrd_beat_o,
  output logic              acc_beat_o,
  output logic              hwr_beat_o,
  output logic              act_done_o,
  output logic              hrd_done_o,
  output logic              acc_done_o,
  output logic              hwr_done_o,
  output logic              ub_read_o,
  output logic [ADDR_W-1:0] ub_addr_rd_o,
  output logic              ub_write_o,
  output logic [ADDR_W-1:0] ub_addr_wr_o,
  output logic              wr_sel_o,
  output logic              rd_valid_o,
  output logic              rd_dst_o
);
  logic rd_busy, rd_owner, rd_stall;
  logic wr_busy, wr_owner;

  ub_port_sched_core #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .STARVE_LIMIT(STARVE_LIMIT)) u_rd (
    .clk(clk_i), .rst_n(rst_i),
    .req_c(act_req_i), .req_h(hrd_req_i),
    .base_c(act_base_i), .base_h(hrd_base_i),
    .len_c(act_len_i), .len_h(hrd_len_i),
    .stall(rd_stall), .busy(rd_busy), .owner(rd_owner), .addr(ub_addr_rd_o),
    .gnt_c(act_gnt_o), .gnt_h(hrd_gnt_o),
    .beat_c(act_beat_o), .beat_h(hrd_beat_o),
    .done_c(act_done_o), .done_h(hrd_done_o)
  );

  ub_port_sched_core #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .STARVE_LIMIT(STARVE_LIMIT)) u_wr (
    .clk(clk_i), .rst_n(rst_i),
    .req_c(acc_req_i), .req_h(hwr_req_i),
    .base_c(acc_base_i), .base_h(hwr_base_i),
    .len_c(acc_len_i), .len_h(hwr_len_i),
    .stall(1'b0), .busy(wr_busy), .owner(wr_owner), .addr(ub_addr_wr_o),
    .gnt_c(acc_gnt_o), .gnt_h(hwr_gnt_o),
    .beat_c(acc_beat_o), .beat_h(hwr_beat_o),
    .done_c(acc_done_o), .done_h(hwr_done_o)
  );

`ifdef UB_SCHED_HAZARD_EN
  // Write beats never stall, so busy is the write beat.
  assign rd_stall = rd_busy && wr_busy && (ub_addr_rd_o == ub_addr_wr_o);
`else
  assign rd_stall = 1'b0;
`endif

  assign ub_read_o  = rd_busy && !rd_stall;
  assign ub_write_o = wr_busy;
  assign wr_sel_o   = wr_busy && wr_owner;

  // Read data return stage
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_valid_o <= 1'b0;
      rd_dst_o   <= 1'b0;
    end else begin
      rd_valid_o <= ub_read_o;
      rd_dst_o   <= ub_read_o && rd_owner;
    end
  end
endmodule

// File: tb/tb_ub_port_scheduler.sv
// Directed bench for ub_port_scheduler (STARVE_LIMIT=4); collision checks follow UB_SCHED_HAZARD_EN.
`timescale 1ns/1ps
module tb_ub_port_scheduler;
  localparam int ADDR_W = 12;
  localparam int LEN_W  = 8;

  logic clk, rst_i;
  logic act_req, hrd_req, acc_req, hwr_req;
  logic [ADDR_W-1:0] act_base, hrd_base, acc_base, hwr_base;
  logic [LEN_W-1:0]  act_len, hrd_len, acc_len, hwr_len;
  logic act_gnt, hrd_gnt, acc_gnt, hwr_gnt;
  logic act_beat, hrd_beat, acc_beat, hwr_beat;
  logic act_done, hrd_done, acc_done, hwr_done;
  logic ub_read, ub_write, wr_sel, rd_valid, rd_dst;
  logic [ADDR_W-1:0] addr_rd, addr_wr;
  logic [16:0] flags;
  int n_chk, n_fail;

  ub_port_scheduler #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .STARVE_LIMIT(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .act_req_i(act_req), .hrd_req_i(hrd_req), .acc_req_i(acc_req), .hwr_req_i(hwr_req),
    .act_base_i(act_base), .hrd_base_i(hrd_base), .acc_base_i(acc_base), .hwr_base_i(hwr_base),
    .act_len_i(act_len), .hrd_len_i(hrd_len), .acc_len_i(acc_len), .hwr_len_i(hwr_len),
    .act_gnt_o(act_gnt), .hrd_gnt_o(hrd_gnt), .acc_gnt_o(acc_gnt), .hwr_gnt_o(hwr_gnt),
    .act_beat_o(act_beat), .hrd_beat_o(hrd_beat), .acc_beat_o(acc_beat), .hwr_beat_o(hwr_beat),
    .act_done_o(act_done), .hrd_done_o(hrd_done), .acc_done_o(acc_done), .hwr_done_o(hwr_done),
    .ub_read_o(ub_read), .ub_addr_rd_o(addr_rd), .ub_write_o(ub_write), .ub_addr_wr_o(addr_wr),
    .wr_sel_o(wr_sel), .rd_valid_o(rd_valid), .rd_dst_o(rd_dst)
  );

  assign flags = {act_gnt, hrd_gnt, acc_gnt, hwr_gnt, act_beat, hrd_beat, acc_beat, hwr_beat,
                  act_done, hrd_done, acc_done, hwr_done, ub_read, ub_write, wr_sel, rd_valid, rd_dst};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [31:0] t1_rd [6] = '{1, 1, 1, 1, 0, 0};
  logic [31:0] t1_gn [6] = '{1, 0, 0, 0, 0, 0};
  logic [31:0] t1_dn [6] = '{0, 0, 0, 1, 0, 0};
  logic [31:0] t1_rv [6] = '{0, 1, 1, 1, 1, 0};
  logic [31:0] t3_wr [6] = '{1, 1, 1, 1, 1, 0};
  logic [31:0] t3_sl [6] = '{0, 0, 0, 1, 1, 0};
  logic [31:0] t3_ad [6] = '{32'h100, 32'h101, 32'h102, 32'h300, 32'h301, 0};
  logic [31:0] t4_ad [4] = '{32'hFFE, 32'hFFF, 32'h000, 32'h001};

  initial begin
    n_chk = 0; n_fail = 0;
    rst_i = 1'b0;
    {act_req, hrd_req, acc_req, hwr_req} = '0;
    act_base = '0; hrd_base = '0; acc_base = '0; hwr_base = '0;
    act_len = '0; hrd_len = '0; acc_len = '0; hwr_len = '0;
    tick;
    check("reset_flags", 32'(flags), 0);
    check("reset_addr_rd", 32'(addr_rd), 0);
    check("reset_addr_wr", 32'(addr_wr), 0);
    rst_i = 1'b1;
    tick;

    // Activation burst, base 0x010, len 3.
    act_base = 12'h010; act_len = 8'd3; act_req = 1'b1;
    tick;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("act_read_%0d", k), 32'(ub_read), t1_rd[k]);
      if (t1_rd[k] == 1) check($sformatf("act_addr_%0d", k), 32'(addr_rd), 32'h010 + 32'(k));
      check($sformatf("act_gnt_%0d", k), 32'(act_gnt), t1_gn[k]);
      check($sformatf("act_done_%0d", k), 32'(act_done), t1_dn[k]);
      check($sformatf("rd_valid_%0d", k), 32'(rd_valid), t1_rv[k]);
      if (t1_rv[k] == 1) check($sformatf("rd_dst_%0d", k), 32'(rd_dst), 0);
      if (k == 0) act_req = 1'b0;
      tick;
    end

    // Starvation: act len 0 back to back against a held host read.
    act_base = 12'h080; act_len = 8'd0; hrd_base = 12'h200; hrd_len = 8'd0;
    act_req = 1'b1; hrd_req = 1'b1;
    tick;
    for (int k = 1; k <= 12; k++) begin
      check($sformatf("starve_hrd_gnt_%0d", k), 32'(hrd_gnt), 32'((k == 5) || (k == 11)));
      check($sformatf("starve_act_gnt_%0d", k), 32'(act_gnt), 32'(!((k == 5) || (k == 11))));
      if (k == 5) check("starve_hrd_addr", 32'(addr_rd), 32'h200);
      if (k == 6) check("starve_hrd_dst", 32'(rd_dst), 1);
      if (k == 12) begin act_req = 1'b0; hrd_req = 1'b0; end
      tick;
    end
    tick; tick;

    // Write port chaining: acc burst then host write with no idle cycle.
    acc_base = 12'h100; acc_len = 8'd2; hwr_base = 12'h300; hwr_len = 8'd1;
    acc_req = 1'b1; hwr_req = 1'b1;
    tick;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("chain_write_%0d", k), 32'(ub_write), t3_wr[k]);
      check($sformatf("chain_sel_%0d", k), 32'(wr_sel), t3_sl[k]);
      if (t3_wr[k] == 1) check($sformatf("chain_addr_%0d", k), 32'(addr_wr), t3_ad[k]);
      if (k == 0) acc_req = 1'b0;
      if (k == 2) check("chain_acc_done", 32'(acc_done), 1);
      if (k == 3) begin check("chain_hwr_gnt", 32'(hwr_gnt), 1); hwr_req = 1'b0; end
      if (k == 4) check("chain_hwr_done", 32'(hwr_done), 1);
      tick;
    end

    // Address wrap on the write port.
    hwr_base = 12'hFFE; hwr_len = 8'd3; hwr_req = 1'b1;
    tick;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("wrap_addr_%0d", k), 32'(addr_wr), t4_ad[k]);
      check($sformatf("wrap_done_%0d", k), 32'(hwr_done), 32'(k == 3));
      if (k == 0) hwr_req = 1'b0;
      tick;
    end
    check("wrap_idle", 32'(ub_write), 0);

    // Asynchronous reset at beat 2 of an 8-beat burst; request held through.
    act_base = 12'h020; act_len = 8'd7; act_req = 1'b1;
    tick; tick; tick;
    check("rst_pre_addr", 32'(addr_rd), 32'h022);
    rst_i = 1'b0;
    #1;
    check("rst_async_flags", 32'(flags), 0);
    check("rst_async_addr_rd", 32'(addr_rd), 0);
    tick;
    check("rst_hold_flags", 32'(flags), 0);
    rst_i = 1'b1;
    tick;
    check("rst_regrant", 32'(act_gnt), 1);
    check("rst_regrant_addr", 32'(addr_rd), 32'h020);
    act_req = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick;
      check($sformatf("rst_burst_done_%0d", k), 32'(act_done), 32'(k == 7));
    end
    tick; tick;

    // Same-cycle read/write at 0x040.
    act_base = 12'h040; act_len = 8'd1; acc_base = 12'h040; acc_len = 8'd0;
    act_req = 1'b1; acc_req = 1'b1;
    tick;
    check("coll_write", 32'(ub_write), 1);
    check("coll_waddr", 32'(addr_wr), 32'h040);
    acc_req = 1'b0;
`ifdef UB_SCHED_HAZARD_EN
    check("coll_read_held", 32'(ub_read), 0);
    check("coll_gnt_held", 32'(act_gnt), 0);
    tick;
    check("coll_reissue_read", 32'(ub_read), 1);
    check("coll_reissue_addr", 32'(addr_rd), 32'h040);
    check("coll_reissue_gnt", 32'(act_gnt), 1);
    act_req = 1'b0;
    tick;
    check("coll_last_addr", 32'(addr_rd), 32'h041);
    check("coll_last_done", 32'(act_done), 1);
`else
    check("coll_read", 32'(ub_read), 1);
    check("coll_raddr", 32'(addr_rd), 32'h040);
    check("coll_gnt", 32'(act_gnt), 1);
    act_req = 1'b0;
    tick;
    check("coll_last_addr", 32'(addr_rd), 32'h041);
    check("coll_last_done", 32'(act_done), 1);
    tick;
    check("coll_idle", 32'(ub_read), 0);
`endif
    tick; tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ub_port_scheduler.md
# ub_port_scheduler

Burst scheduler for the unified buffer's independent read and write ports. Two requesters share each port: activation fetch (compute side) and host readback share the read port; accumulator writeback (compute side) and host load share the write port. Each port grants whole bursts and drives the buffer address, enable and source-select signals. Compute requesters have fixed priority, and a starvation counter bounds host latency.

## Interface
Parameters:
- ADDR_W, 12, unified buffer address width
- LEN_W, 8, burst length field width; a burst is len+1 beats
- STARVE_LIMIT, 16, host wait cycles before the host is forced ahead of compute; range 1..255

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-low reset
- act_req_i, hrd_req_i  in  1  read-port burst requests (activation fetch, host read)
- acc_req_i, hwr_req_i  in  1  write-port burst requests (accumulator writeback, host write)
- {act,hrd,acc,hwr}_base_i  in  ADDR_W  burst start address, sampled at grant
- {act,hrd,acc,hwr}_len_i  in  LEN_W  beats minus one, sampled at grant
- {act,hrd,acc,hwr}_gnt_o  out  1  one-cycle grant pulse, coincident with the first beat
- {act,hrd,acc,hwr}_beat_o  out  1  a beat is issued for this requester this cycle
- {act,hrd,acc,hwr}_done_o  out  1  one-cycle pulse on the last beat
- ub_read_o  out  1  unified buffer read enable
- ub_addr_rd_o  out  ADDR_W  read address
- ub_write_o  out  1  unified buffer write enable
- ub_addr_wr_o  out  ADDR_W  write address
- wr_sel_o  out  1  write-data mux select: 0 = accumulator, 1 = host
- rd_valid_o  out  1  read data valid at buffer output; ub_read_o delayed one cycle
- rd_dst_o  out  1  destination of the returning read data: 0 = activation staging, 1 = host

## Operation
- Each port has an independent FSM with two states:
  - IDLE to BURST when a request wins arbitration.
  - BURST to BURST when another request wins on the last beat (zero-bubble chaining).
  - BURST to IDLE on the last beat when no request is pending.
- Arbitration runs in IDLE and on the last-beat cycle of BURST. The winner's base and len are latched and its gnt_o pulses in the next cycle, together with beat 0.
- Priority is compute first (act, acc). A port's host requester wins instead when that port's starvation counter is at or above STARVE_LIMIT.
- Starvation counter, one per port, 8-bit saturating:
  - increments each cycle the host request is high and not granted;
  - clears on host grant;
  - holds while the host request is low.
- Address counter starts at base, increments by 1 per beat and wraps modulo 2^ADDR_W. For example, base 0xFFE with len 3 issues 0xFFE, 0xFFF, 0x000, 0x001.
- Requesters hold req high until gnt. req still high after done counts as a new request.
- Write data: the granted requester drives data combinationally in the cycle its beat_o is high. wr_sel_o is valid in the same cycle.
- Read data returns one cycle after ub_read_o. rd_valid_o and rd_dst_o are registered copies of ub_read_o and the read-port owner.
- A request arriving while its own port is busy waits. The two ports never block each other.

## Timing
- Request at cycle t with the port IDLE: gnt_o and beat 0 at t+1, last beat and done_o at t+1+len, rd_valid_o for the last beat at t+2+len.
- Chained burst: beat 0 of the next burst is at t+2+len, with no idle cycle.
- len=0: gnt_o, beat_o and done_o all pulse in the same cycle.
- Simultaneous compute and host requests with the counter below the limit: compute wins and the host counter increments.
- Reset (rst_i low, asynchronous):
  - FSMs go to IDLE, counters to 0.
  - All outputs go to 0, including ub_read_o, ub_write_o, addresses, gnt_o, beat_o, done_o, rd_valid_o, rd_dst_o and wr_sel_o.
  - A burst in progress is abandoned without a done pulse.
- Release is sampled on clk_i. The first grant is possible in the cycle after the first rising edge with rst_i high.

## Configuration
- UB_SCHED_HAZARD_EN defined:
  - If a read beat would hit the same address as a write beat issued in the same cycle, the read beat is withheld for that cycle: ub_read_o=0, beat_o=0, and the address and remaining-count registers hold.
  - The read beat reissues in the next cycle. Write beats are never stalled.
- Undefined: no comparison is made. The buffer returns old data on a same-cycle collision (read-first).

## Test plan
- act_req with base 0x010 and len 3 at cycle 5 -> act_gnt and ub_read_o at cycle 6; addresses 0x010..0x013 in cycles 6..9; act_done at 9; rd_valid_o in cycles 7..10 with rd_dst_o=0.
- act_req held continuously with len 0 and hrd_req held high, STARVE_LIMIT=4 -> hrd is granted after exactly 4 wait cycles, then its counter returns to 0.
- acc burst ending at cycle 20 with hwr_req pending -> hwr beat 0 at cycle 21 with wr_sel_o=1 and no idle cycle.
- hwr base 0xFFE with len 3 -> ub_addr_wr_o sequence 0xFFE, 0xFFF, 0x000, 0x001.
- rst_i low mid-burst at beat 2 of 8 -> all outputs 0 immediately, no done pulse; the same request held high after release is granted again from its base.
- With UB_SCHED_HAZARD_EN defined, read and write both at 0x040 in the same cycle -> ub_read_o=0 that cycle, read of 0x040 reissued next cycle, write unaffected.
